mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_addr  in  32  icache line-fill address; i_read  in  1  icache fill request, level, held until i_resp.
REQ-004 i_rdata  out  256  filled line; i_resp  out  1  one-cycle completion pulse to icache.
REQ-005 d_addr  in  32; d_read  in  1; d_write  in  1  dcache fill/writeback requests, level, held until d_resp, never both high.
REQ-006 d_wdata  in  256  writeback line; d_rdata  out  256; d_resp  out  1  one-cycle completion pulse to dcache.
REQ-007 bmem_addr  out  32; bmem_read  out  1; bmem_write  out  1; bmem_wdata  out  64  burst-memory command side.
REQ-008 bmem_ready  in  1; bmem_raddr  in  32; bmem_rdata  in  64; bmem_rvalid  in  1  burst-memory status/return side.

Function
REQ-009 Line = 256 bits = 4 beats of 64; beat k maps to line bits [64k+63:64k].
REQ-010 bmem_addr SHALL be the granted address with bits [4:0] forced to 0.
REQ-011 FSM states IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP.
REQ-012 IDLE with no unmasked request: stay IDLE, all bmem command outputs 0.
REQ-013 IDLE arbitration: dcache alone wins; icache alone wins; both pending: grant goes opposite of last_grant (round-robin); last_grant reset value = icache, so first contention grants dcache.
REQ-014 Grant to a read (i_read or d_read): IDLE -> RD_ISSUE; grant to d_write: IDLE -> WR_BURST with beat counter 0.
REQ-015 RD_ISSUE: drive bmem_read=1 with aligned address; advance to RD_WAIT on the cycle bmem_ready=1; hold command while bmem_ready=0.
REQ-016 RD_WAIT: each bmem_rvalid=1 cycle stores bmem_rdata into beat[count], count increments (2-bit); on the 4th beat go to RESP.
REQ-017 bmem_rvalid SHALL be ignored in IDLE, RD_ISSUE, WR_BURST, RESP.
REQ-018 WR_BURST: bmem_write=1, bmem_wdata=d_wdata beat[count]; count advances only on cycles with bmem_ready=1; beat held while bmem_ready=0; after beat 3 accepted go to RESP.
REQ-019 RESP: exactly one cycle; assert i_resp or d_resp for the granted requester only, with i_rdata/d_rdata = assembled line (write: d_rdata don't-care); then -> IDLE; last_grant updated to served requester.
REQ-020 i_rdata/d_rdata SHALL remain stable from RESP until the next read grant to that port.
REQ-021 In the IDLE cycle directly after RESP, the just-served requester is masked from arbitration (requester drops its request in that cycle); the other requester may be granted.
REQ-022 Fill latency: request seen in IDLE -> resp = 1 (RD_ISSUE, ready=1) + beat return cycles + 1 (RESP); minimum with back-to-back rvalid: 7 cycles from request to resp.
REQ-023 Writeback latency with bmem_ready always 1: WR_BURST 4 cycles, resp in the 6th cycle after request is sampled in IDLE.
REQ-024 At most one bmem transaction outstanding; no new grant until RESP completes.
REQ-025 Request deassertion by a cache mid-transaction SHALL NOT abort the transaction.

Reset
REQ-026 rst=1 forces IDLE, count=0, last_grant=icache, all outputs 0 (i_resp, d_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, i_rdata, d_rdata) in the following cycle.
REQ-027 rst asserted mid-burst: transaction discarded, no resp issued, late rvalid beats ignored after reset.

Verification
REQ-028 Icache-only fill: i_read, i_addr=0x1ECEB01C, ready=1, 4 back-to-back rvalid beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x1ECEB000, i_resp one cycle, i_rdata={0x44..,0x33..,0x22..,0x11..}, d_resp=0.
REQ-029 Simultaneous i_read and d_read after reset -> dcache served first; icache granted in IDLE cycle after d_resp; next contention grants icache.
REQ-030 Dcache writeback, d_wdata=beats A,B,C,D, bmem_ready low on 2nd beat for 3 cycles -> bmem_wdata sequence A,B,B,B,B,C,D, exactly 4 accepted beats, d_resp once.
REQ-031 Stray bmem_rvalid while IDLE or WR_BURST -> no state change, no resp, data outputs unchanged.
REQ-032 rst pulsed after 2 of 4 read beats -> no resp; fresh request afterward completes normally with correct data.
REQ-033 Back-to-back: d_write then d_read queued with i_read pending -> order d_write, i_read, d_read; resps each exactly one cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - icache/dcache arbiter onto a 64-bit burst memory port
//
// Purpose: serves 256-bit line fills for the icache and dcache, and 256-bit
// writebacks for the dcache, as 4-beat bursts on a single burst-memory port.
// Only one burst is in flight at a time. Contention is resolved round-robin.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_addr, i_read      icache fill request (level, held until i_resp)
//   i_rdata, i_resp     icache filled line and one-cycle completion pulse
//   d_addr, d_read,     dcache fill / writeback request (level, held until d_resp)
//   d_write, d_wdata
//   d_rdata, d_resp     dcache filled line and one-cycle completion pulse
//   bmem_addr,          burst command: line-aligned address, read/write strobes,
//   bmem_read,          write beat data
//   bmem_write,
//   bmem_wdata
//   bmem_ready          memory accepts the current command / write beat
//   bmem_raddr          return address (not needed: one burst outstanding)
//   bmem_rdata,         read beat return
//   bmem_rvalid
module mem_port_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t       state;
  logic [1:0]   count;
  logic         last_grant;
  logic         grant;
  logic         mask_valid;
  // Beats 0..2 of a read; beat 3 goes straight into the output line.
  logic [191:0] line_buf;

  logic         i_req;
  logic         d_req;
  logic         pick_d;
  logic         any_req;
  logic [1:0]   next_idx;

  // Only one burst is ever outstanding, so the return address carries no
  // information we need.
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;

  // Arbitration. The requester served by the preceding RESP is masked for the
  // one IDLE cycle that follows, since its level request may still be high.
  always_comb begin
    i_req    = i_read & ~(mask_valid & (grant == GRANT_I));
    d_req    = (d_read | d_write) & ~(mask_valid & (grant == GRANT_D));
    // Under contention grant goes opposite to the last served requester.
    pick_d   = d_req & (~i_req | (last_grant == GRANT_I));
    any_req  = i_req | d_req;
    next_idx = count + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 2'd0;
      last_grant <= GRANT_I;
      grant      <= GRANT_I;
      mask_valid <= 1'b0;
      line_buf   <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;

      case (state)
        IDLE: begin
          mask_valid <= 1'b0;
          if (any_req) begin
            grant     <= pick_d;
            count     <= 2'd0;
            bmem_addr <= (pick_d ? d_addr : i_addr) & 32'hFFFF_FFE0;
            if (pick_d && d_write) begin
              state      <= WR_BURST;
              bmem_write <= 1'b1;
              bmem_wdata <= d_wdata[63:0];
            end else begin
              state     <= RD_ISSUE;
              bmem_read <= 1'b1;
            end
          end
        end

        RD_ISSUE: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bmem_rvalid) begin
            count <= next_idx;
            if (count == 2'd3) begin
              state     <= RESP;
              bmem_addr <= '0;
              if (grant == GRANT_D) begin
                d_rdata <= {bmem_rdata, line_buf};
                d_resp  <= 1'b1;
              end else begin
                i_rdata <= {bmem_rdata, line_buf};
                i_resp  <= 1'b1;
              end
            end else begin
              line_buf[{count, 6'b0} +: 64] <= bmem_rdata;
            end
          end
        end

        WR_BURST: begin
          // The current beat stays on the bus until memory accepts it.
          if (bmem_ready) begin
            count <= next_idx;
            if (count == 2'd3) begin
              state      <= RESP;
              bmem_write <= 1'b0;
              bmem_wdata <= '0;
              bmem_addr  <= '0;
              d_resp     <= 1'b1;
            end else begin
              bmem_wdata <= d_wdata[{next_idx, 6'b0} +: 64];
            end
          end
        end

        RESP: begin
          state      <= IDLE;
          count      <= 2'd0;
          last_grant <= grant;
          mask_valid <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_addr      (d_addr),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the RD_ISSUE cycle (bmem_ready=1): steps into RD_WAIT, returns
  // four back-to-back beats and leaves the bench in the RESP cycle.
  task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] beats [4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    step();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = beats[k];
      step();
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [63:0] WB = 64'hBBBB_0000_BBBB_0002;
  localparam logic [63:0] WC = 64'hCCCC_0000_CCCC_0003;
  localparam logic [63:0] WD = 64'hDDDD_0000_DDDD_0004;

  logic [63:0]  wr_exp [7];
  logic         wr_rdy [7];
  logic [255:0] saved_i;
  logic [255:0] saved_d;
  int           accepted;
  int           saw_resp;

  initial begin
    rst = 1'b1;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_i_resp", {255'd0, i_resp}, 256'd0);
    chk("rst_d_resp", {255'd0, d_resp}, 256'd0);
    chk("rst_bmem_read", {255'd0, bmem_read}, 256'd0);
    chk("rst_bmem_write", {255'd0, bmem_write}, 256'd0);
    chk("rst_bmem_addr", {224'd0, bmem_addr}, 256'd0);
    chk("rst_bmem_wdata", {192'd0, bmem_wdata}, 256'd0);
    chk("rst_i_rdata", i_rdata, 256'd0);
    chk("rst_d_rdata", d_rdata, 256'd0);
    rst = 1'b0;
    step();
    chk("idle_no_req_read", {255'd0, bmem_read}, 256'd0);

    // Icache-only fill, minimum latency
    i_addr = 32'h1ECE_B01C; i_read = 1'b1; bmem_ready = 1'b1;
    step();
    chk("if_issue_read", {255'd0, bmem_read}, 256'd1);
    chk("if_issue_addr", {224'd0, bmem_addr}, {224'd0, 32'h1ECE_B000});
    chk("if_issue_write", {255'd0, bmem_write}, 256'd0);
    read_beats(B1, B2, B3, B4);
    chk("if_i_resp", {255'd0, i_resp}, 256'd1);
    chk("if_d_resp", {255'd0, d_resp}, 256'd0);
    chk("if_i_rdata", i_rdata, {B4, B3, B2, B1});
    i_read = 1'b0;
    step();
    chk("if_i_resp_drop", {255'd0, i_resp}, 256'd0);
    chk("if_i_rdata_hold", i_rdata, {B4, B3, B2, B1});

    // Stray rvalid while IDLE
    bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step(); step(); step();
    chk("stray_idle_rdata", i_rdata, {B4, B3, B2, B1});
    chk("stray_idle_i_resp", {255'd0, i_resp}, 256'd0);
    chk("stray_idle_d_resp", {255'd0, d_resp}, 256'd0);
    chk("stray_idle_read", {255'd0, bmem_read}, 256'd0);
    bmem_rvalid = 1'b0;

    // Contention right after reset: dcache first, icache next (dcache masked)
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_i_rdata", i_rdata, 256'd0);
    i_addr = 32'h0000_1047; i_read = 1'b1;
    d_addr = 32'h0000_2074; d_read = 1'b1;
    step();
    chk("ct_first_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_2060});
    read_beats(B4, B3, B2, B1);
    chk("ct_d_resp", {255'd0, d_resp}, 256'd1);
    chk("ct_i_resp_lo", {255'd0, i_resp}, 256'd0);
    chk("ct_d_rdata", d_rdata, {B1, B2, B3, B4});
    step();
    chk("ct_d_resp_once", {255'd0, d_resp}, 256'd0);
    d_read = 1'b0;
    step();
    chk("ct_second_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_1040});
    chk("ct_second_read", {255'd0, bmem_read}, 256'd1);
    read_beats(B2, B2, B3, B3);
    chk("ct_i_resp", {255'd0, i_resp}, 256'd1);
    chk("ct_i_rdata", i_rdata, {B3, B3, B2, B2});
    chk("ct_d_rdata_hold", d_rdata, {B1, B2, B3, B4});
    i_read = 1'b0;
    step();
    saved_i = i_rdata;
    saved_d = d_rdata;

    // Writeback with ready stalls on beat B, stray rvalid during the burst
    wr_exp[0] = WA; wr_exp[1] = WB; wr_exp[2] = WB; wr_exp[3] = WB;
    wr_exp[4] = WB; wr_exp[5] = WC; wr_exp[6] = WD;
    wr_rdy[0] = 1'b1; wr_rdy[1] = 1'b0; wr_rdy[2] = 1'b0; wr_rdy[3] = 1'b0;
    wr_rdy[4] = 1'b1; wr_rdy[5] = 1'b1; wr_rdy[6] = 1'b1;
    d_wdata = {WD, WC, WB, WA}; d_addr = 32'h0000_3ABC; d_write = 1'b1;
    step();
    chk("wb_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_3AA0});
    accepted = 0;
    bmem_rvalid = 1'b1; bmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    for (int k = 0; k < 7; k++) begin
      bmem_ready = wr_rdy[k];
      chk($sformatf("wb_write_%0d", k), {255'd0, bmem_write}, 256'd1);
      chk($sformatf("wb_wdata_%0d", k), {192'd0, bmem_wdata}, {192'd0, wr_exp[k]});
      if (bmem_write && bmem_ready) accepted++;
      step();
    end
    bmem_rvalid = 1'b0; bmem_ready = 1'b1;
    chk("wb_accepted", accepted, 4);
    chk("wb_d_resp", {255'd0, d_resp}, 256'd1);
    chk("wb_write_done", {255'd0, bmem_write}, 256'd0);
    chk("wb_i_rdata_hold", i_rdata, saved_i);
    d_write = 1'b0;
    step();
    chk("wb_d_resp_once", {255'd0, d_resp}, 256'd0);

    // Reset after two read beats; late beats ignored, then a clean fill
    i_addr = 32'h0000_4000; i_read = 1'b1;
    step();
    step();
    bmem_rvalid = 1'b1; bmem_rdata = B1; step();
    bmem_rdata = B2; step();
    rst = 1'b1; i_read = 1'b0; bmem_rdata = B3;
    step();
    rst = 1'b0; bmem_rdata = B4;
    chk("mr_read_off", {255'd0, bmem_read}, 256'd0);
    chk("mr_i_rdata_clr", i_rdata, 256'd0);
    saw_resp = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      bmem_rvalid = 1'b0;
      if (i_resp || d_resp) saw_resp++;
    end
    chk("mr_no_resp", saw_resp, 0);
    i_addr = 32'h0000_5020; i_read = 1'b1;
    step();
    chk("mr_fresh_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_5020});
    read_beats(WA, WB, WC, WD);
    chk("mr_fresh_resp", {255'd0, i_resp}, 256'd1);
    chk("mr_fresh_data", i_rdata, {WD, WC, WB, WA});
    i_read = 1'b0;
    step();

    // Back-to-back: d_write, then i_read, then the queued d_read
    rst = 1'b1; step(); rst = 1'b0;
    d_wdata = {WA, WB, WC, WD}; d_addr = 32'h0000_6000; d_write = 1'b1;
    i_addr = 32'h0000_7000; i_read = 1'b1;
    step();
    chk("bb_wr_write", {255'd0, bmem_write}, 256'd1);
    chk("bb_wr_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_6000});
    step(); step(); step(); step();
    chk("bb_wr_d_resp", {255'd0, d_resp}, 256'd1);
    chk("bb_wr_i_resp", {255'd0, i_resp}, 256'd0);
    d_write = 1'b0; d_read = 1'b1; d_addr = 32'h0000_8000;
    step();
    chk("bb_wr_resp_once", {255'd0, d_resp}, 256'd0);
    step();
    chk("bb_i_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_7000});
    chk("bb_i_read", {255'd0, bmem_read}, 256'd1);
    read_beats(B1, B1, B4, B4);
    chk("bb_i_resp", {255'd0, i_resp}, 256'd1);
    chk("bb_i_d_resp", {255'd0, d_resp}, 256'd0);
    chk("bb_i_rdata", i_rdata, {B4, B4, B1, B1});
    i_read = 1'b0;
    step();
    chk("bb_i_resp_once", {255'd0, i_resp}, 256'd0);
    step();
    chk("bb_d_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_8000});
    read_beats(WD, WC, WB, WA);
    chk("bb_d_resp", {255'd0, d_resp}, 256'd1);
    chk("bb_d_rdata", d_rdata, {WA, WB, WC, WD});
    d_read = 1'b0;
    step();
    chk("bb_d_resp_once", {255'd0, d_resp}, 256'd0);
    step();

    // Fresh contention after a dcache service goes to icache
    i_addr = 32'h0000_9000; i_read = 1'b1;
    d_addr = 32'h0000_A000; d_read = 1'b1;
    step();
    chk("rr_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_9000});
    read_beats(B3, B1, B3, B1);
    chk("rr_i_resp", {255'd0, i_resp}, 256'd1);
    chk("rr_i_rdata", i_rdata, {B1, B3, B1, B3});
    i_read = 1'b0; d_read = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
